// File: rtl/dma_burst_reader_pkg.sv
// Shared definitions for the DMA burst reader: memory geometry and FSM encoding.
package dma_burst_reader_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int MEM_WORDS = 32768;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dma_burst_reader_stream_fifo.sv
// Small synchronous FIFO with occupancy count; holds read data plus a last-byte tag.
module stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the data array is deliberately not reset; occupancy is tracked by count,
  // so stale entries are never visible and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) storage[wptr] <= wdata;
  end

  assign rdata = storage[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/dma_burst_reader.sv
// Streams a contiguous block of scratch-memory bytes onto a valid/ready stream,
// throttling reads so the output FIFO can absorb every byte already requested.
module dma_burst_reader #(
  parameter int ADDR_W     = dma_burst_reader_pkg::ADDR_W,
  parameter int DATA_W     = dma_burst_reader_pkg::DATA_W,
  parameter int LEN_W      = 16,
  parameter int MEM_WORDS  = dma_burst_reader_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  import dma_burst_reader_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              err_q, err_d;
  logic              rd_inflight_q;
  logic              last_inflight_q;
  logic [LEN_W:0]    end_addr;
  logic              range_bad;
  logic              credit;
  logic              pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_head;

  assign end_addr  = (LEN_W+1)'(base_addr) + {1'b0, length};
  assign range_bad = end_addr > (LEN_W+1)'(MEM_WORDS);

  // A read may only go out if its byte is guaranteed a FIFO slot on arrival,
  // counting the read still in flight from the previous cycle.
  assign credit = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(rd_inflight_q))
                  < (CNT_W+1)'(FIFO_DEPTH);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    err_d   = 1'b0;
    mem_rd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = ST_DONE;
          end else if (range_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            left_d  = length;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (credit) begin
          mem_rd = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          left_d = left_q - LEN_W'(1);
          if (left_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      left_q          <= '0;
      err_q           <= 1'b0;
      rd_inflight_q   <= 1'b0;
      last_inflight_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      left_q          <= left_d;
      err_q           <= err_d;
      rd_inflight_q   <= mem_rd;
      last_inflight_q <= mem_rd && (left_q == LEN_W'(1));
    end
  end

  // Memory data returns one cycle after the strobe, together with its last tag.
  stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .push  (rd_inflight_q),
    .wdata ({last_inflight_q, mem_rdata}),
    .pop   (pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DATA_W-1:0];
  assign out_last  = out_valid && fifo_head[DATA_W];
  assign pop       = out_valid && out_ready;

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_wr    = 1'b0;
  assign mem_wdata = '0;

endmodule

// File: tb/tb_dma_burst_reader.sv
// Self-checking bench for dma_burst_reader: memory model, stream collector and
// per-scenario checks against expectations computed from the memory contents.
module tb_dma_burst_reader;

  localparam int MEM_WORDS  = 32768;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, err;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;

  dma_burst_reader dut (
    .clk       (clk),
    .RST       (RST),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Scratch memory model: read data valid the cycle after the strobe.
  logic [7:0] mem [0:MEM_WORDS-1];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[14:0]];

  int tests = 0;
  int fails = 0;

  // Continuous protocol monitor with an occupancy model built from strobes and handshakes.
  int       occ = 0;
  bit       prev_rd = 1'b0;
  bit       prev_stall = 1'b0;
  logic [7:0] stall_data;
  logic     stall_last;

  always @(negedge clk) begin
    if (RST) begin
      occ = 0; prev_rd = 1'b0; prev_stall = 1'b0;
    end else begin
      tests++;
      if (mem_wr !== 1'b0 || mem_wdata !== 8'h00) begin
        fails++; $display("FAIL mem_write_idle: mem_wr=%0b mem_wdata=%02h, required 0/00", mem_wr, mem_wdata);
      end
      tests++;
      if (out_valid !== (occ > 0)) begin
        fails++; $display("FAIL valid_vs_occupancy: out_valid=%0b, required %0b (occ=%0d)", out_valid, occ > 0, occ);
      end
      if (mem_rd === 1'b1) begin
        tests++;
        if (occ + int'(prev_rd) >= FIFO_DEPTH || mem_addr >= MEM_WORDS) begin
          fails++; $display("FAIL read_credit: occ=%0d inflight=%0b addr=%04h, required occ+inflight<%0d and addr in range",
                            occ, prev_rd, mem_addr, FIFO_DEPTH);
        end
      end
      if (prev_rd && occ - int'(out_valid && out_ready) >= FIFO_DEPTH) begin
        tests++; fails++;
        $display("FAIL fifo_overflow: push with occupancy %0d, required < %0d", occ, FIFO_DEPTH);
      end
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== stall_data || out_last !== stall_last) begin
          fails++; $display("FAIL stall_stable: valid=%0b data=%02h last=%0b, required 1/%02h/%0b",
                            out_valid, out_data, out_last, stall_data, stall_last);
        end
      end
      prev_stall = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      occ        = occ + int'(prev_rd) - int'(out_valid && out_ready);
      prev_rd    = mem_rd;
    end
  end

  // Results of the most recent burst (cycle 0 is the cycle in which start is high).
  logic [7:0] got_q [$];
  bit         last_q [$];
  int         hs_cyc_q [$];
  int n_done, n_err, n_rd, n_busy, first_rd_cyc, first_valid_cyc, done_cyc;
  bit timed_out;

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return ($urandom % 4) != 0;
    endcase
  endfunction

  // Drives one start and records the stream; called at posedge+1.
  task automatic do_burst(input logic [15:0] b, input logic [15:0] l, input int mode,
                          input int restart_cyc, input int abort_after);
    int  tail;
    bit  finished;
    got_q.delete(); last_q.delete(); hs_cyc_q.delete();
    n_done = 0; n_err = 0; n_rd = 0; n_busy = 0;
    first_rd_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
    tail = -1; finished = 1'b0;
    start = 1'b1; base_addr = b; length = l; out_ready = ready_for(mode, 0);
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      if (mem_rd) begin n_rd++; if (first_rd_cyc < 0) first_rd_cyc = cyc; end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data); last_q.push_back(out_last); hs_cyc_q.push_back(cyc);
      end
      if (done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
      if (err)  n_err++;
      if (busy) n_busy++;
      if ((done || err) && tail < 0) tail = 4;
      @(posedge clk); #1;
      start = (cyc + 1 == restart_cyc);
      if (start) base_addr = b + 16'h0100;
      out_ready = ready_for(mode, cyc + 1);
      if (abort_after > 0 && got_q.size() >= abort_after) begin
        RST = 1'b1; finished = 1'b1;
      end else if (tail > 0) begin
        tail--;
        if (tail == 0) finished = 1'b1;
      end
    end
    start = 1'b0;
    timed_out = !finished;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({busy, done, err, mem_rd, mem_wr, out_valid, out_last} !== 7'b0) begin
      fails++; $display("FAIL reset_flags: busy/done/err/rd/wr/valid/last=%07b, required 0000000",
                        {busy, done, err, mem_rd, mem_wr, out_valid, out_last});
    end
    tests++;
    if (mem_addr !== 16'h0000) begin
      fails++; $display("FAIL reset_addr: mem_addr=%04h, required 0000", mem_addr);
    end
    @(posedge clk); #1; RST = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) mem[32'h0100 + i] = exp_b[i];
    do_burst(16'h0100, 16'd4, 0, -1, 0);
    tests++;
    if (timed_out || got_q.size() != 4) begin
      fails++; $display("FAIL basic_count: got %0d bytes (timeout=%0b), required 4", got_q.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_q[i] !== exp_b[i] || last_q[i] !== (i == 3) || hs_cyc_q[i] != 3 + i) begin
          fails++; $display("FAIL basic_byte[%0d]: data=%02h last=%0b cyc=%0d, required %02h/%0b/%0d",
                            i, got_q[i], last_q[i], hs_cyc_q[i], exp_b[i], i == 3, 3 + i);
        end
      end
    end
    tests++;
    if (first_rd_cyc != 1 || first_valid_cyc != 3) begin
      fails++; $display("FAIL basic_latency: first rd cyc %0d, first valid cyc %0d, required 1 and 3", first_rd_cyc, first_valid_cyc);
    end
    tests++;
    if (n_done != 1 || done_cyc != 7 || n_rd != 4 || n_busy != 6) begin
      fails++; $display("FAIL basic_done: done x%0d at cyc %0d, reads %0d, busy cycles %0d, required 1 at 7, 4, 6",
                        n_done, done_cyc, n_rd, n_busy);
    end
  endtask

  // Checks the recorded stream against mem[b .. b+l-1] and exactly one done.
  task automatic check_stream(input string tag, input int b, input int l);
    tests++;
    if (timed_out || got_q.size() != l || n_done != 1 || n_rd != l || n_err != 0) begin
      fails++; $display("FAIL %s_summary: bytes %0d reads %0d done %0d err %0d timeout %0b, required %0d %0d 1 0 0",
                        tag, got_q.size(), n_rd, n_done, n_err, timed_out, l, l);
    end else begin
      for (int i = 0; i < l; i++) begin
        tests++;
        if (got_q[i] !== mem[b + i] || last_q[i] !== (i == l - 1)) begin
          fails++; $display("FAIL %s_byte[%0d]: data=%02h last=%0b, required %02h/%0b",
                            tag, i, got_q[i], last_q[i], mem[b + i], i == l - 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int b;
    b = int'($urandom_range(MEM_WORDS - 16, 0));
    for (int i = 0; i < 16; i++) mem[b + i] = 8'($urandom);
    do_burst(16'(b), 16'd16, 1, -1, 0);
    check_stream("backpressure", b, 16);
  endtask

  task automatic test_zero_length();
    do_burst(16'h1234, 16'd0, 0, -1, 0);
    tests++;
    if (n_rd != 0 || first_valid_cyc != -1 || n_busy != 0 || n_err != 0) begin
      fails++; $display("FAIL zero_len_quiet: reads %0d valid at %0d busy %0d err %0d, required 0 -1 0 0",
                        n_rd, first_valid_cyc, n_busy, n_err);
    end
    tests++;
    if (n_done != 1 || done_cyc < 1 || done_cyc > 2) begin
      fails++; $display("FAIL zero_len_done: done x%0d at cyc %0d, required once within 2 cycles", n_done, done_cyc);
    end
  endtask

  task automatic test_range_error();
    do_burst(16'h7FFE, 16'd3, 0, -1, 0);
    tests++;
    if (n_err != 1 || n_rd != 0 || n_busy != 0 || n_done != 0 || got_q.size() != 0) begin
      fails++; $display("FAIL range_err: err %0d reads %0d busy %0d done %0d bytes %0d, required 1 0 0 0 0",
                        n_err, n_rd, n_busy, n_done, got_q.size());
    end
    mem[32'h7FFE] = 8'($urandom);
    mem[32'h7FFF] = 8'($urandom);
    do_burst(16'h7FFE, 16'd2, 0, -1, 0);
    check_stream("range_edge", 32'h7FFE, 2);
  endtask

  task automatic test_reset_mid_burst();
    int b;
    int bad;
    b = int'($urandom_range(MEM_WORDS - 10, 0));
    for (int i = 0; i < 10; i++) mem[b + i] = 8'($urandom);
    do_burst(16'(b), 16'd10, 0, -1, 3);
    @(posedge clk); #1; RST = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || n_done != 0) begin
      fails++; $display("FAIL abort_state: valid=%0b busy=%0b done=%0b dones=%0d, required 0 0 0 0",
                        out_valid, busy, done, n_done);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || mem_rd || out_valid || busy) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
    end
    @(posedge clk); #1;
    b = int'($urandom_range(MEM_WORDS - 5, 0));
    for (int i = 0; i < 5; i++) mem[b + i] = 8'($urandom);
    do_burst(16'(b), 16'd5, 0, -1, 0);
    check_stream("after_abort", b, 5);
  endtask

  task automatic test_start_ignored();
    int b;
    b = int'($urandom_range(MEM_WORDS - 8 - 16'h0100, 0));
    for (int i = 0; i < 8; i++) begin
      mem[b + i]          = 8'($urandom);
      mem[b + 16'h0100 + i] = ~mem[b + i];
    end
    do_burst(16'(b), 16'd8, 0, 2, 0);
    check_stream("start_ignored", b, 8);
  endtask

  task automatic test_random();
    int b;
    int l;
    for (int k = 0; k < 6; k++) begin
      l = int'($urandom_range(40, 1));
      b = int'($urandom_range(MEM_WORDS - l, 0));
      for (int i = 0; i < l; i++) mem[b + i] = 8'($urandom);
      do_burst(16'(b), 16'(l), 2, -1, 0);
      check_stream("random", b, l);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_backpressure();
    test_zero_length();
    test_range_error();
    test_reset_mid_burst();
    test_start_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
